// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states,
// flag bit positions and opcode classification helpers.
package alu_pkg;

  // Opcode map; 0x00-0x0F match the original combinational ALU
  localparam logic [4:0] OP_ADDU = 5'h00;
  localparam logic [4:0] OP_ADDS = 5'h01;
  localparam logic [4:0] OP_SUBU = 5'h02;
  localparam logic [4:0] OP_SUBS = 5'h03;
  localparam logic [4:0] OP_MULU = 5'h04;
  localparam logic [4:0] OP_MULS = 5'h05;
  localparam logic [4:0] OP_DIVU = 5'h06;
  localparam logic [4:0] OP_DIVS = 5'h07;
  localparam logic [4:0] OP_AND  = 5'h08;
  localparam logic [4:0] OP_OR   = 5'h09;
  localparam logic [4:0] OP_XOR  = 5'h0A;
  localparam logic [4:0] OP_NOTA = 5'h0B;
  localparam logic [4:0] OP_SHR  = 5'h0C;
  localparam logic [4:0] OP_SHL  = 5'h0D;
  localparam logic [4:0] OP_ROR  = 5'h0E;
  localparam logic [4:0] OP_ROL  = 5'h0F;
  localparam logic [4:0] OP_SAR  = 5'h10;
  localparam logic [4:0] OP_REMU = 5'h11;
  localparam logic [4:0] OP_REMS = 5'h12;
  localparam logic [4:0] OP_SLTS = 5'h13;
  localparam logic [4:0] OP_SLTU = 5'h14;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bit positions inside the flags vector {illegal, div0, ovf, neg, zero}
  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_NEG     = 1;
  localparam int FLAG_OVF     = 2;
  localparam int FLAG_DIV0    = 3;
  localparam int FLAG_ILLEGAL = 4;

  // Ops that need the multi-cycle multiply/divide engine
  function automatic logic is_iterative(input logic [4:0] op);
    case (op)
      OP_MULU, OP_MULS, OP_DIVU, OP_DIVS, OP_REMU, OP_REMS: is_iterative = 1'b1;
      default:                                              is_iterative = 1'b0;
    endcase
  endfunction

  // Ops that run the divider (quotient or remainder)
  function automatic logic is_div_type(input logic [4:0] op);
    case (op)
      OP_DIVU, OP_DIVS, OP_REMU, OP_REMS: is_div_type = 1'b1;
      default:                            is_div_type = 1'b0;
    endcase
  endfunction

  // Iterative ops whose operands are two's complement and need sign fixing
  function automatic logic is_signed_md(input logic [4:0] op);
    case (op)
      OP_MULS, OP_DIVS, OP_REMS: is_signed_md = 1'b1;
      default:                   is_signed_md = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned engine: shift-add multiply or restoring divide on
// operand magnitudes. One step per clock, WIDTH steps after a load.
// lo/hi hold product low/high halves, or quotient/remainder.
module seq_muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic             last,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] den_q;
  logic             mode_q;
  logic             running;
  logic [SHW-1:0]   cnt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] hi_n;

  // Multiply adds the multiplicand into the high half when the current
  // multiplier bit is set; the carry is kept so the right shift loses nothing.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, den_q} : '0);
  // Divide shifts the next dividend bit into the partial remainder and
  // trial-subtracts the divisor; a borrow means the subtraction is undone.
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, den_q};

  // One iteration step of whichever algorithm was loaded
  always_comb begin
    lo_n = lo_q;
    hi_n = hi_q;
    if (mode_q) begin
      if (!div_trial[WIDTH]) begin
        hi_n = div_trial[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = div_shift[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Load operands, then step WIDTH times and stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q    <= '0;
      hi_q    <= '0;
      den_q   <= '0;
      mode_q  <= 1'b0;
      running <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      lo_q    <= mag_a;
      hi_q    <= '0;
      den_q   <= mag_b;
      mode_q  <= mode;
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      lo_q <= lo_n;
      hi_q <= hi_n;
      cnt  <= cnt + SHW'(1);
      if (&cnt) begin
        running <= 1'b0;
      end
    end
  end

  assign last = running & (&cnt);
  assign lo   = lo_q;
  assign hi   = hi_q;

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU between register file and writeback. Single-cycle ops finish
// one cycle after accept; multiply/divide/remainder use the iterative core
// followed by a sign-correction cycle. Results and flags are held until
// the next done pulse.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       flags
);

  localparam int               SHW     = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW:0]     WIDTH_S = (SHW+1)'(WIDTH);

  state_t state;
  state_t next_state;

  logic             accept;
  logic             in_div_zero;
  logic             core_load;
  logic             core_last;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic [WIDTH-1:0] core_lo;
  logic [WIDTH-1:0] core_hi;

  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] fix_hi;

  logic [2*WIDTH-1:0] core_prod;
  logic [2*WIDTH-1:0] core_prod_neg;
  logic               res_sign_neg;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_sovf;
  logic             sub_sovf;
  logic [SHW-1:0]   sh_amt;
  logic [SHW:0]     sh_inv;
  logic             sh_big;
  logic             b_zero;

  logic [WIDTH-1:0] fin_res;
  logic [WIDTH-1:0] fin_hi;
  logic [4:0]       fin_flags;
  logic             f_ovf;
  logic             f_div0;
  logic             f_illegal;

  // A start is only taken while idle; division by zero bypasses the engine
  assign accept      = (state == ST_IDLE) && start;
  assign in_div_zero = is_div_type(op) && (b == '0);
  assign core_load   = accept && is_iterative(op) && !in_div_zero;
  assign mag_a_in    = (is_signed_md(op) && a[WIDTH-1]) ? -a : a;
  assign mag_b_in    = (is_signed_md(op) && b[WIDTH-1]) ? -b : b;
  assign busy        = (state != ST_IDLE);

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (core_load),
    .mode  (is_div_type(op)),
    .mag_a (mag_a_in),
    .mag_b (mag_b_in),
    .last  (core_last),
    .lo    (core_lo),
    .hi    (core_hi)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE -> (ITER -> FIX ->) DONE -> IDLE
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (is_iterative(op) && !in_div_zero) ? ST_ITER : ST_DONE;
        end
      end
      ST_ITER: begin
        if (core_last) begin
          next_state = ST_FIX;
        end
      end
      ST_FIX:  next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Capture op and operands on the accepting edge only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
  end

  assign core_prod     = {core_hi, core_lo};
  assign core_prod_neg = -core_prod;
  assign res_sign_neg  = a_q[WIDTH-1] ^ b_q[WIDTH-1];

  // Sign correction of the engine's magnitude results during FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fix_lo <= '0;
      fix_hi <= '0;
    end else if (state == ST_FIX) begin
      case (op_q)
        OP_MULS: begin
          {fix_hi, fix_lo} <= res_sign_neg ? core_prod_neg : core_prod;
        end
        OP_DIVS, OP_REMS: begin
          fix_lo <= res_sign_neg ? -core_lo : core_lo;
          fix_hi <= a_q[WIDTH-1] ? -core_hi : core_hi;
        end
        default: begin
          fix_lo <= core_lo;
          fix_hi <= core_hi;
        end
      endcase
    end
  end

  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sub_full = {1'b0, a_q} - {1'b0, b_q};
  assign add_sovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_sovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_full[WIDTH-1] != a_q[WIDTH-1]);
  assign sh_amt   = b_q[SHW-1:0];
  assign sh_inv   = WIDTH_S - {1'b0, sh_amt};
  assign sh_big   = |b_q[WIDTH-1:SHW];
  assign b_zero   = (b_q == '0);

  // Final result, high half and flags presented to the output registers in DONE
  always_comb begin
    fin_res   = '0;
    fin_hi    = '0;
    f_ovf     = 1'b0;
    f_div0    = 1'b0;
    f_illegal = 1'b0;
    case (op_q)
      OP_ADDU: begin
        fin_res = add_full[WIDTH-1:0];
        f_ovf   = add_full[WIDTH];
      end
      OP_ADDS: begin
        fin_res = add_full[WIDTH-1:0];
        f_ovf   = add_sovf;
      end
      OP_SUBU: begin
        fin_res = sub_full[WIDTH-1:0];
        f_ovf   = sub_full[WIDTH];
      end
      OP_SUBS: begin
        fin_res = sub_full[WIDTH-1:0];
        f_ovf   = sub_sovf;
      end
      OP_MULU: begin
        fin_res = fix_lo;
        fin_hi  = fix_hi;
        f_ovf   = (fix_hi != '0);
      end
      OP_MULS: begin
        fin_res = fix_lo;
        fin_hi  = fix_hi;
        f_ovf   = (fix_hi != {WIDTH{fix_lo[WIDTH-1]}});
      end
      OP_DIVU, OP_DIVS: begin
        if (b_zero) begin
          fin_res = '1;
          fin_hi  = a_q;
          f_div0  = 1'b1;
        end else begin
          fin_res = fix_lo;
          fin_hi  = fix_hi;
          f_ovf   = (op_q == OP_DIVS) && (a_q == MIN_VAL) && (&b_q);
        end
      end
      OP_REMU, OP_REMS: begin
        if (b_zero) begin
          fin_res = a_q;
          f_div0  = 1'b1;
        end else begin
          fin_res = fix_hi;
        end
      end
      OP_AND:  fin_res = a_q & b_q;
      OP_OR:   fin_res = a_q | b_q;
      OP_XOR:  fin_res = a_q ^ b_q;
      OP_NOTA: fin_res = ~a_q;
      OP_SHR:  fin_res = sh_big ? '0 : (a_q >> sh_amt);
      OP_SHL:  fin_res = sh_big ? '0 : (a_q << sh_amt);
      OP_ROR:  fin_res = (a_q >> sh_amt) | (a_q << sh_inv);
      OP_ROL:  fin_res = (a_q << sh_amt) | (a_q >> sh_inv);
      OP_SAR:  fin_res = sh_big ? {WIDTH{a_q[WIDTH-1]}} : $unsigned($signed(a_q) >>> sh_amt);
      OP_SLTS: fin_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: fin_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      default: f_illegal = 1'b1;
    endcase
    fin_flags               = '0;
    fin_flags[FLAG_ZERO]    = (fin_res == '0);
    fin_flags[FLAG_NEG]     = fin_res[WIDTH-1];
    fin_flags[FLAG_OVF]     = f_ovf;
    fin_flags[FLAG_DIV0]    = f_div0;
    fin_flags[FLAG_ILLEGAL] = f_illegal;
  end

  // Output registers: load in DONE and pulse done for exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else begin
      done <= (state == ST_DONE);
      if (state == ST_DONE) begin
        result    <= fin_res;
        result_hi <= fin_hi;
        flags     <= fin_flags;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes model predictions, a
// monitor pops and compares on every done pulse (values and latency).
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [4:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [4:0]   flags;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [4:0]   flags;
    int           lat;
    int           done_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks     = 0;
  int   passes     = 0;
  int   done_count = 0;

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  function automatic logic fits32(input longint v);
    logic [63:0] u;
    u = v;
    return v == longint'($signed(u[31:0]));
  endfunction

  // Reference model built from native arithmetic on 64-bit values
  function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx, sy, sl;
    logic [63:0] p;
    logic [32:0] s;
    logic        ill, dz, ov;
    int          r;
    sx = $signed(x);
    sy = $signed(y);
    e.res = '0; e.hi = '0; e.lat = 1; e.done_cyc = 0;
    ill = 1'b0; dz = 1'b0; ov = 1'b0;
    case (o)
      5'h00: begin s = {1'b0, x} + {1'b0, y}; e.res = s[31:0]; ov = s[32]; end
      5'h01: begin sl = sx + sy; p = sl; e.res = p[31:0]; ov = !fits32(sl); end
      5'h02: begin e.res = x - y; ov = (x < y); end
      5'h03: begin sl = sx - sy; p = sl; e.res = p[31:0]; ov = !fits32(sl); end
      5'h04: begin
        p = {32'b0, x} * {32'b0, y};
        e.res = p[31:0]; e.hi = p[63:32]; ov = (e.hi != 0); e.lat = W + 2;
      end
      5'h05: begin
        sl = sx * sy; p = sl;
        e.res = p[31:0]; e.hi = p[63:32]; ov = !fits32(sl); e.lat = W + 2;
      end
      5'h06: begin
        if (y == 0) begin e.res = '1; e.hi = x; dz = 1'b1; end
        else begin e.res = x / y; e.hi = x % y; e.lat = W + 2; end
      end
      5'h07: begin
        if (y == 0) begin e.res = '1; e.hi = x; dz = 1'b1; end
        else begin
          e.lat = W + 2;
          if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            e.res = 32'h80000000; e.hi = 0; ov = 1'b1;
          end else begin
            sl = sx / sy; p = sl; e.res = p[31:0];
            sl = sx % sy; p = sl; e.hi = p[31:0];
          end
        end
      end
      5'h08: e.res = x & y;
      5'h09: e.res = x | y;
      5'h0A: e.res = x ^ y;
      5'h0B: e.res = ~x;
      5'h0C: e.res = (y >= 32) ? 32'h0 : x >> y;
      5'h0D: e.res = (y >= 32) ? 32'h0 : x << y;
      5'h0E: begin r = int'(y % 32); e.res = (r == 0) ? x : ((x >> r) | (x << (32 - r))); end
      5'h0F: begin r = int'(y % 32); e.res = (r == 0) ? x : ((x << r) | (x >> (32 - r))); end
      5'h10: e.res = (y >= 32) ? {32{x[31]}} : $unsigned($signed(x) >>> y);
      5'h11: begin
        if (y == 0) begin e.res = x; dz = 1'b1; end
        else begin e.res = x % y; e.lat = W + 2; end
      end
      5'h12: begin
        if (y == 0) begin e.res = x; dz = 1'b1; end
        else begin sl = sx % sy; p = sl; e.res = p[31:0]; e.lat = W + 2; end
      end
      5'h13: e.res = (sx < sy) ? 32'd1 : 32'd0;
      5'h14: e.res = (x < y) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
    e.flags = {ill, dz, ov, e.res[31], (e.res == 0)};
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding prediction
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_count++;
      if (sb_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, required no pending response", cyc);
      end else begin
        e = sb_q.pop_front();
        check_output("result", result, e.res);
        check_output("result_hi", result_hi, e.hi);
        check_output("flags", 32'(flags), 32'(e.flags));
        check_output("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  // Issue one op at a negedge; returns at the negedge after the accepting edge
  task automatic apply_stimulus(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e = model(o, x, y);
    e.done_cyc = cyc + 1 + e.lat;
    sb_q.push_back(e);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 5'($urandom); a = $urandom; b = $urandom;
    check_output("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL %s_timeout: %0d responses outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'($urandom_range(0, 40));
      2:       return 32'h80000000;
      3:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc;
    int n;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_result", result, 32'd0);
    check_output("rst_result_hi", result_hi, 32'd0);
    check_output("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single-cycle ops");
    apply_stimulus(5'h00, 32'h10, 32'h3); wait_drain("add"); check_output("plan_add", result, 32'h13);
    apply_stimulus(5'h02, 32'h10, 32'h3); wait_drain("sub"); check_output("plan_sub", result, 32'hD);
    apply_stimulus(5'h0C, 32'h10, 32'h3); wait_drain("shr"); check_output("plan_shr", result, 32'h2);
    apply_stimulus(5'h0D, 32'h10, 32'h3); wait_drain("shl"); check_output("plan_shl", result, 32'h80);

    $display("[TB] multiply");
    apply_stimulus(5'h05, 32'hFFFFFFFA, 32'd7); wait_drain("muls");
    check_output("plan_muls_lo", result, 32'hFFFFFFD6);
    check_output("plan_muls_hi", result_hi, 32'hFFFFFFFF);
    check_output("plan_muls_flags", 32'(flags), 32'h02);
    apply_stimulus(5'h04, 32'hFFFFFFFF, 32'd2); wait_drain("mulu");
    check_output("plan_mulu_lo", result, 32'hFFFFFFFE);
    check_output("plan_mulu_hi", result_hi, 32'h1);
    check_output("plan_mulu_flags", 32'(flags), 32'h06);

    $display("[TB] divide");
    apply_stimulus(5'h07, 32'hFFFFFFF9, 32'd2); wait_drain("divs");
    check_output("plan_divs_q", result, 32'hFFFFFFFD);
    check_output("plan_divs_r", result_hi, 32'hFFFFFFFF);
    apply_stimulus(5'h06, 32'd16, 32'd3); wait_drain("divu");
    check_output("plan_divu_q", result, 32'd5);
    check_output("plan_divu_r", result_hi, 32'd1);
    apply_stimulus(5'h07, 32'h80000000, 32'hFFFFFFFF); wait_drain("divs_min");
    check_output("plan_divs_min_q", result, 32'h80000000);
    check_output("plan_divs_min_flags", 32'(flags), 32'h06);
    apply_stimulus(5'h06, 32'h1234, 32'd0); wait_drain("div0");
    check_output("plan_div0_q", result, 32'hFFFFFFFF);
    check_output("plan_div0_r", result_hi, 32'h1234);
    check_output("plan_div0_flags", 32'(flags), 32'h0A);

    $display("[TB] shift boundaries");
    apply_stimulus(5'h0C, 32'hDEADBEEF, 32'd40); wait_drain("shr40");
    check_output("plan_shr40", result, 32'h0);
    apply_stimulus(5'h10, 32'h80000000, 32'd40); wait_drain("sar40");
    check_output("plan_sar40", result, 32'hFFFFFFFF);
    apply_stimulus(5'h0F, 32'h80000001, 32'd33); wait_drain("rol33");
    check_output("plan_rol33", result, 32'h3);
    apply_stimulus(5'h0E, 32'hCAFEF00D, 32'd0); wait_drain("ror0");
    check_output("plan_ror0", result, 32'hCAFEF00D);

    $display("[TB] handshake");
    dc = done_count;
    apply_stimulus(5'h06, 32'd16, 32'd3);
    @(negedge clk);
    op = 5'h00; a = 32'd1; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignored_start");
    repeat (5) @(negedge clk);
    check_output("hs_single_done", 32'(done_count - dc), 32'd1);
    check_output("hs_quotient", result, 32'd5);
    apply_stimulus(5'h00, 32'd7, 32'd8);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_output("b2b_done_seen", 32'(done), 32'd1);
    apply_stimulus(5'h02, 32'd100, 32'd1);
    wait_drain("b2b");
    check_output("b2b_second", result, 32'd99);

    $display("[TB] reset mid-operation");
    apply_stimulus(5'h05, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_result", result, 32'd0);
    check_output("abort_result_hi", result_hi, 32'd0);
    check_output("abort_flags", 32'(flags), 32'd0);
    sb_q.delete();
    dc = done_count;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    check_output("abort_no_done", 32'(done_count - dc), 32'd0);
    apply_stimulus(5'h01, 32'd5, 32'hFFFFFFFD); wait_drain("after_reset");
    check_output("after_reset_add", result, 32'd2);
    apply_stimulus(5'h1F, 32'h55, 32'hAA); wait_drain("illegal");
    check_output("plan_illegal_res", result, 32'd0);
    check_output("plan_illegal_flags", 32'(flags), 32'h11);

    $display("[TB] randomized ops");
    for (int i = 0; i < 250; i++) begin
      logic [4:0]   o;
      logic [W-1:0] x, y;
      if ($urandom_range(0, 9) == 0) o = 5'($urandom_range(21, 31));
      else o = 5'($urandom_range(0, 20));
      x = rand_operand();
      y = rand_operand();
      apply_stimulus(o, x, y);
      wait_drain("rand");
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
